// File: rtl/mem_op.sv
// 32x32 RGB444 pixel memory with a host read/write port and a Sobel edge engine
// that scans the whole image and reports |Gx|>>2 and |Gy|>>2 per pixel.
module mem_op (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        sobel_en,
    input  logic [9:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic [9:0]  rd_addr,
    output logic [11:0] data_out,
    output logic [3:0]  wr_gx,
    output logic [3:0]  wr_gy,
    output logic        sobel_done
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_READ0 = 4'd1;
    localparam logic [3:0] S_READ8 = 4'd9;
    localparam logic [3:0] S_LAST  = 4'd10;
    localparam logic [3:0] S_CALC  = 4'd11;
    localparam logic [3:0] S_DONE  = 4'd12;

    logic [11:0] mem [0:1023];
    logic [3:0]  state;
    logic [9:0]  pix;

    logic [11:0] sob_data;
    logic        sob_pend;
    logic        sob_ok;
    logic [3:0]  sob_k;
    logic signed [7:0] gx_acc;
    logic signed [7:0] gy_acc;

    logic        reading;
    logic [3:0]  nb_k;
    logic [1:0]  row_sel;
    logic [1:0]  col_sel;
    logic [4:0]  nb_row;
    logic [4:0]  nb_col;
    logic        nb_ok;
    logic [9:0]  sob_addr;

    // Neighbour k of the 3x3 window, row-major; off-image neighbours are flagged
    // so the returning sample is replaced by gray 0 instead of wrapping.
    always_comb begin
        reading = (state >= S_READ0) && (state <= S_READ8);
        nb_k    = reading ? (state - S_READ0) : 4'd0;
        case (nb_k)
            4'd0, 4'd1, 4'd2: row_sel = 2'd0;
            4'd3, 4'd4, 4'd5: row_sel = 2'd1;
            default:          row_sel = 2'd2;
        endcase
        case (nb_k)
            4'd0, 4'd3, 4'd6: col_sel = 2'd0;
            4'd1, 4'd4, 4'd7: col_sel = 2'd1;
            default:          col_sel = 2'd2;
        endcase
        nb_row = pix[9:5];
        nb_col = pix[4:0];
        nb_ok  = reading;
        if (row_sel == 2'd0) begin
            nb_row = pix[9:5] - 5'd1;
            if (pix[9:5] == 5'd0) nb_ok = 1'b0;
        end else if (row_sel == 2'd2) begin
            nb_row = pix[9:5] + 5'd1;
            if (pix[9:5] == 5'd31) nb_ok = 1'b0;
        end
        if (col_sel == 2'd0) begin
            nb_col = pix[4:0] - 5'd1;
            if (pix[4:0] == 5'd0) nb_ok = 1'b0;
        end else if (col_sel == 2'd2) begin
            nb_col = pix[4:0] + 5'd1;
            if (pix[4:0] == 5'd31) nb_ok = 1'b0;
        end
        sob_addr = {nb_row, nb_col};
    end

    always_ff @(posedge clk) begin
        if (wr_en && state == S_IDLE)
            mem[wr_addr] <= wr_data;
        sob_data <= mem[sob_addr];
    end

    logic [5:0]        gray_sum;
    logic signed [7:0] g1;
    logic signed [7:0] g2;
    logic [7:0]        gx_mag;
    logic [7:0]        gy_mag;

    always_comb begin
        gray_sum = {2'b00, sob_data[11:8]} + {1'b0, sob_data[7:4], 1'b0} + {2'b00, sob_data[3:0]};
        g1       = sob_ok ? $signed({4'b0000, gray_sum[5:2]}) : 8'sd0;
        g2       = g1 <<< 1;
        gx_mag   = gx_acc[7] ? $unsigned(-gx_acc) : $unsigned(gx_acc);
        gy_mag   = gy_acc[7] ? $unsigned(-gy_acc) : $unsigned(gy_acc);
    end

    // Samples arrive one cycle after their address, so accumulation trails the
    // READ states by one; the last sample lands on the LAST->CALC edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pix        <= 10'd0;
            data_out   <= 12'd0;
            wr_gx      <= 4'd0;
            wr_gy      <= 4'd0;
            sobel_done <= 1'b0;
            sob_pend   <= 1'b0;
            sob_ok     <= 1'b0;
            sob_k      <= 4'd0;
            gx_acc     <= 8'sd0;
            gy_acc     <= 8'sd0;
        end else begin
            data_out   <= mem[rd_addr];
            sob_pend   <= reading;
            sob_ok     <= nb_ok;
            sob_k      <= nb_k;
            sobel_done <= (state == S_DONE) && sobel_en;
            if (sob_pend) begin
                case (sob_k)
                    4'd0: begin gx_acc <= gx_acc - g1; gy_acc <= gy_acc - g1; end
                    4'd1: gy_acc <= gy_acc - g2;
                    4'd2: begin gx_acc <= gx_acc + g1; gy_acc <= gy_acc - g1; end
                    4'd3: gx_acc <= gx_acc - g2;
                    4'd5: gx_acc <= gx_acc + g2;
                    4'd6: begin gx_acc <= gx_acc - g1; gy_acc <= gy_acc + g1; end
                    4'd7: gy_acc <= gy_acc + g2;
                    4'd8: begin gx_acc <= gx_acc + g1; gy_acc <= gy_acc + g1; end
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: begin
                    if (sobel_en) begin
                        pix    <= 10'd0;
                        gx_acc <= 8'sd0;
                        gy_acc <= 8'sd0;
                        state  <= S_READ0;
                    end
                end
                S_LAST: state <= S_CALC;
                S_CALC: begin
                    wr_gx  <= gx_mag[5:2];
                    wr_gy  <= gy_mag[5:2];
                    gx_acc <= 8'sd0;
                    gy_acc <= 8'sd0;
                    if (pix == 10'd1023) begin
                        state <= S_DONE;
                    end else begin
                        pix   <= pix + 10'd1;
                        state <= S_READ0;
                    end
                end
                S_DONE: begin
                    if (!sobel_en) state <= S_IDLE;
                end
                default: state <= reading ? (state + 4'd1) : S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_op.sv
// Bench for mem_op: directed host-port steps plus full-image scans compared
// pixel by pixel against a behavioural Sobel model of the stored image.
module tb_mem_op;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        sobel_en = 1'b0;
    logic [9:0]  wr_addr = 10'd0;
    logic [11:0] wr_data = 12'd0;
    logic [9:0]  rd_addr = 10'd0;
    logic [11:0] data_out;
    logic [3:0]  wr_gx;
    logic [3:0]  wr_gy;
    logic        sobel_done;

    logic [11:0] model [0:1023];
    int seen_gx [0:1023];
    int seen_gy [0:1023];
    int vectors = 0;
    int miscompares = 0;

    mem_op dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .sobel_en(sobel_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .data_out(data_out), .wr_gx(wr_gx), .wr_gy(wr_gy), .sobel_done(sobel_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_write(input int addr, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_addr = 10'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        model[addr] = data;
    endtask

    // mode 0: uniform 0xFFF, 1: vertical edge at column 16, 2: random pixels
    task automatic apply_stimulus(input int mode);
        logic [11:0] p;
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       p = 12'hFFF;
                1:       p = ((a % 32) < 16) ? 12'h000 : 12'hAAA;
                default: p = 12'($urandom);
            endcase
            apply_write(a, p);
        end
    endtask

    function automatic int gray_of(input logic [11:0] p);
        return (int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0])) / 4;
    endfunction

    function automatic void model_grad(input int n, output int gx, output int gy);
        int r, c, v, sx, sy;
        sx = 0;
        sy = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = n / 32 + dr;
                c = n % 32 + dc;
                v = (r >= 0 && r < 32 && c >= 0 && c < 32) ? gray_of(model[r * 32 + c]) : 0;
                sx += dc * ((dr == 0) ? 2 : 1) * v;
                sy += dr * ((dc == 0) ? 2 : 1) * v;
            end
        end
        gx = ((sx < 0) ? -sx : sx) / 4;
        gy = ((sy < 0) ? -sy : sy) / 4;
    endfunction

    // Starts a scan from IDLE and checks every pixel 11(n+1) edges after E0.
    // Returns at E0+11264 plus 1 time unit.
    task automatic run_scan(input string name, input bit drop_en, input bit poke);
        int gx, gy;
        sobel_en = 1'b1;
        tick();
        if (drop_en) sobel_en = 1'b0;
        if (poke) begin
            wr_en   = 1'b1;
            wr_addr = 10'd0;
            wr_data = 12'h123;
        end
        for (int n = 0; n < 1024; n++) begin
            repeat (11) @(posedge clk);
            #1;
            wr_en = 1'b0;
            model_grad(n, gx, gy);
            seen_gx[n] = int'(wr_gx);
            seen_gy[n] = int'(wr_gy);
            check_output($sformatf("%s gx[%0d]", name, n), 32'(wr_gx), 32'(gx));
            check_output($sformatf("%s gy[%0d]", name, n), 32'(wr_gy), 32'(gy));
        end
    endtask

    initial begin
        $display("[TB] start");
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset data_out", 32'(data_out), 32'd0);
        check_output("reset wr_gx", 32'(wr_gx), 32'd0);
        check_output("reset wr_gy", 32'(wr_gy), 32'd0);
        check_output("reset sobel_done", 32'(sobel_done), 32'd0);
        rst = 1'b1;
        tick();

        apply_write(0, 12'hFFF);
        apply_write(1, 12'hAAA);
        apply_write(2, 12'hAAF);
        rd_addr = 10'd0; tick();
        check_output("read addr0", 32'(data_out), 32'hFFF);
        rd_addr = 10'd1; tick();
        check_output("read addr1", 32'(data_out), 32'hAAA);
        rd_addr = 10'd2; tick();
        check_output("read addr2", 32'(data_out), 32'hAAF);

        rd_addr = 10'd1;
        apply_write(1, 12'h555);
        check_output("read during write old", 32'(data_out), 32'hAAA);
        tick();
        check_output("read after write new", 32'(data_out), 32'h555);

        apply_stimulus(0);
        run_scan("uniform", 1'b0, 1'b1);
        check_output("uniform px0 gx", 32'(seen_gx[0]), 32'd11);
        check_output("uniform px0 gy", 32'(seen_gy[0]), 32'd11);
        check_output("uniform px33 gx", 32'(seen_gx[33]), 32'd0);
        check_output("uniform px33 gy", 32'(seen_gy[33]), 32'd0);
        check_output("uniform px1023 gx", 32'(seen_gx[1023]), 32'd11);
        check_output("uniform px1023 gy", 32'(seen_gy[1023]), 32'd11);
        check_output("done low at last update", 32'(sobel_done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_output("done held high", 32'(sobel_done), 32'd1);
            check_output("no restart gx", 32'(wr_gx), 32'd11);
        end
        sobel_en = 1'b0;
        tick();
        check_output("done falls", 32'(sobel_done), 32'd0);
        rd_addr = 10'd0; tick();
        check_output("write lockout addr0", 32'(data_out), 32'hFFF);

        apply_stimulus(1);
        run_scan("edge", 1'b1, 1'b0);
        check_output("edge px175 gx", 32'(seen_gx[32 * 5 + 15]), 32'd10);
        check_output("edge px175 gy", 32'(seen_gy[32 * 5 + 15]), 32'd0);
        check_output("edge px180 gx", 32'(seen_gx[32 * 5 + 20]), 32'd0);
        check_output("edge px180 gy", 32'(seen_gy[32 * 5 + 20]), 32'd0);
        tick();
        check_output("done stays low without en", 32'(sobel_done), 32'd0);

        apply_stimulus(2);
        run_scan("random", 1'b1, 1'b0);
        tick();

        rd_addr  = 10'd5;
        sobel_en = 1'b1;
        repeat (300) tick();
        check_output("read during scan", 32'(data_out), 32'(model[5]));
        #2 rst = 1'b0;
        #1;
        check_output("midscan reset data_out", 32'(data_out), 32'd0);
        check_output("midscan reset wr_gx", 32'(wr_gx), 32'd0);
        check_output("midscan reset wr_gy", 32'(wr_gy), 32'd0);
        check_output("midscan reset sobel_done", 32'(sobel_done), 32'd0);
        sobel_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rd_addr = 10'd7;
        apply_write(7, 12'h5A5);
        tick();
        check_output("write after reset", 32'(data_out), 32'h5A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
